// File: rtl/if_fetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// if_fetch_ctrl_if
//   Groups the signals between the IF fetch sequencer and its neighbours
//   (hazard unit, branch resolution, instruction memory, IF/ID register).
//
//   Signals
//     stall          hazard unit: hold IF/ID and PC
//     branch_taken   redirect request from branch resolution
//     branch_target  redirect address (low two bits ignored)
//     imem_ready     instruction memory: data for outstanding request valid
//     imem_req       instruction memory read request
//     imem_addr      instruction memory read address
//     if_id_we       IF/ID register load enable
//     if_id_flush    IF/ID register clear (bubble)
//     pc_out         current PC
//     pc_plus4       pc_out + step, IF/ID next-address field
//
//   Modports
//     master  the fetch sequencer
//     slave   the surrounding pipeline / memory
// ----------------------------------------------------------------------------
interface if_fetch_ctrl_if;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_ready;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        if_id_we;
   logic        if_id_flush;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;

   modport master (
      input  stall, branch_taken, branch_target, imem_ready,
      output imem_req, imem_addr, if_id_we, if_id_flush, pc_out, pc_plus4
   );

   modport slave (
      output stall, branch_taken, branch_target, imem_ready,
      input  imem_req, imem_addr, if_id_we, if_id_flush, pc_out, pc_plus4
   );
endinterface

// File: rtl/if_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// if_fetch_ctrl
//   Fetch sequencer for the IF stage. Owns the PC, runs the instruction-memory
//   request handshake, and produces IF/ID load/flush controls while resolving
//   hazard stalls and taken-branch redirects.
//
//   Ports
//     clk    clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    if_fetch_ctrl_if.master (see interface file for signal list)
//
//   Parameters
//     RESET_PC  PC loaded on reset (word aligned)
//     PC_STEP   sequential PC increment in bytes
// ----------------------------------------------------------------------------
module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   if_fetch_ctrl_if.master   bus
);

   localparam logic [31:0] STEP = 32'(PC_STEP);

   // BOOT: one idle cycle after reset. FETCH: request outstanding.
   // HOLD: stalled with fetched data refused. DRAIN: waiting for the response
   // of a request abandoned by a redirect.
   typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] target;

   assign target       = {bus.branch_target[31:2], 2'b00};
   assign bus.pc_out   = pc;
   assign bus.imem_addr = pc;
   assign bus.pc_plus4 = pc + STEP;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BOOT;
         pc    <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   // Priority everywhere: branch_taken > stall > imem_ready.
   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      bus.imem_req    = 1'b0;
      bus.if_id_we    = 1'b0;
      bus.if_id_flush = 1'b0;
      unique case (state)
         BOOT: begin
            state_nxt = FETCH;
         end
         FETCH: begin
            bus.imem_req = 1'b1;
            if (bus.branch_taken) begin
               pc_nxt          = target;
               bus.if_id_flush = 1'b1;
               // Without a response this cycle the request is still in flight.
               state_nxt       = bus.imem_ready ? FETCH : DRAIN;
            end else if (bus.stall) begin
               // Stall without data keeps waiting; the stall is re-evaluated
               // once the data arrives.
               if (bus.imem_ready) state_nxt = HOLD;
            end else if (bus.imem_ready) begin
               bus.if_id_we = 1'b1;
               pc_nxt       = pc + STEP;
            end
         end
         HOLD: begin
            if (bus.branch_taken) begin
               pc_nxt          = target;
               bus.if_id_flush = 1'b1;
               state_nxt       = FETCH;
            end else if (!bus.stall) begin
               state_nxt = FETCH;
            end
         end
         DRAIN: begin
            if (bus.branch_taken) begin
               pc_nxt          = target;
               bus.if_id_flush = 1'b1;
            end
            // Late response is discarded; if_id_we stays low.
            if (bus.imem_ready) state_nxt = FETCH;
         end
         default: begin
            state_nxt = BOOT;
         end
      endcase
   end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic        we;
      logic        fl;
   } exp_t;

   exp_t exp_q[$];

   if_fetch_ctrl_if bus ();

   if_fetch_ctrl #(
      .RESET_PC (32'h0000_0000),
      .PC_STEP  (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic req, input logic [31:0] addr,
                           input logic we, input logic fl);
      exp_t e;
      e.req  = req;
      e.addr = addr;
      e.we   = we;
      e.fl   = fl;
      exp_q.push_back(e);
   endtask

   task automatic check_out();
      exp_t        e;
      logic [31:0] plus;
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL scoreboard observed=empty required=entry");
         return;
      end
      e    = exp_q.pop_front();
      plus = e.addr + 32'd4;
      chk("imem_req",    {31'd0, bus.imem_req},    {31'd0, e.req});
      chk("imem_addr",   bus.imem_addr,            e.addr);
      chk("pc_out",      bus.pc_out,               e.addr);
      chk("pc_plus4",    bus.pc_plus4,             plus);
      chk("if_id_we",    {31'd0, bus.if_id_we},    {31'd0, e.we});
      chk("if_id_flush", {31'd0, bus.if_id_flush}, {31'd0, e.fl});
   endtask

   // Drive inputs shortly after a rising edge, compare on the falling edge.
   task automatic step(input logic st, input logic br, input logic [31:0] tgt,
                       input logic rdy, input logic e_req, input logic [31:0] e_addr,
                       input logic e_we, input logic e_fl);
      bus.stall         = st;
      bus.branch_taken  = br;
      bus.branch_target = tgt;
      bus.imem_ready    = rdy;
      push_exp(e_req, e_addr, e_we, e_fl);
      @(negedge clk);
      check_out();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors           = 0;
      miscompares       = 0;
      rst_n             = 1'b0;
      bus.stall         = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = 32'h0;
      bus.imem_ready    = 1'b0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      push_exp(1'b0, 32'h0, 1'b0, 1'b0);
      check_out();
      rst_n = 1'b1;

      // BOOT, then READY tied high: one fetch per cycle
      step(0, 0, 32'h0, 1, 0, 32'h0000_0000, 0, 0);
      step(0, 0, 32'h0, 1, 1, 32'h0000_0000, 1, 0);
      step(0, 0, 32'h0, 1, 1, 32'h0000_0004, 1, 0);
      step(0, 0, 32'h0, 1, 1, 32'h0000_0008, 1, 0);

      // READY two cycles after each request
      step(0, 0, 32'h0, 0, 1, 32'h0000_000C, 0, 0);
      step(0, 0, 32'h0, 0, 1, 32'h0000_000C, 0, 0);
      step(0, 0, 32'h0, 1, 1, 32'h0000_000C, 1, 0);
      step(0, 0, 32'h0, 0, 1, 32'h0000_0010, 0, 0);
      step(0, 0, 32'h0, 0, 1, 32'h0000_0010, 0, 0);
      step(0, 0, 32'h0, 1, 1, 32'h0000_0010, 1, 0);

      // Stall coincident with READY -> HOLD; stray READY in HOLD ignored
      step(1, 0, 32'h0, 1, 1, 32'h0000_0014, 0, 0);
      step(1, 0, 32'h0, 1, 0, 32'h0000_0014, 0, 0);
      step(1, 0, 32'h0, 0, 0, 32'h0000_0014, 0, 0);
      step(0, 0, 32'h0, 0, 0, 32'h0000_0014, 0, 0);
      step(0, 0, 32'h0, 1, 1, 32'h0000_0014, 1, 0);

      // Branch with READY, stall overridden; target low bits masked
      step(1, 1, 32'h0000_0103, 1, 1, 32'h0000_0018, 0, 1);
      step(0, 0, 32'h0, 1, 1, 32'h0000_0100, 1, 0);

      // Branch while request outstanding -> DRAIN, second branch in DRAIN
      step(0, 1, 32'h0000_0200, 0, 1, 32'h0000_0104, 0, 1);
      step(0, 0, 32'h0, 0, 0, 32'h0000_0200, 0, 0);
      step(0, 1, 32'h0000_0300, 0, 0, 32'h0000_0200, 0, 1);
      step(0, 0, 32'h0, 1, 0, 32'h0000_0300, 0, 0);
      step(0, 0, 32'h0, 1, 1, 32'h0000_0300, 1, 0);

      // Stall without READY keeps waiting in FETCH
      step(1, 0, 32'h0, 0, 1, 32'h0000_0304, 0, 0);
      step(0, 0, 32'h0, 1, 1, 32'h0000_0304, 1, 0);

      // PC wrap at top of address space
      step(0, 1, 32'hFFFF_FFFE, 1, 1, 32'h0000_0308, 0, 1);
      step(0, 0, 32'h0, 1, 1, 32'hFFFF_FFFC, 1, 0);
      step(0, 0, 32'h0, 1, 1, 32'h0000_0000, 1, 0);

      // Enter DRAIN, then assert reset mid-cycle: no clock edge needed
      step(0, 1, 32'h0000_0040, 0, 1, 32'h0000_0004, 0, 1);
      bus.branch_taken = 1'b0;
      bus.imem_ready   = 1'b0;
      push_exp(1'b0, 32'h0000_0040, 1'b0, 1'b0);
      @(negedge clk);
      check_out();
      #2;
      rst_n = 1'b0;
      #1;
      push_exp(1'b0, 32'h0, 1'b0, 1'b0);
      check_out();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // BOOT ignores a branch, then fetch from reset PC
      step(0, 1, 32'h0000_0080, 0, 0, 32'h0000_0000, 0, 0);
      step(0, 0, 32'h0, 1, 1, 32'h0000_0000, 1, 0);
      step(0, 0, 32'h0, 1, 1, 32'h0000_0004, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Fetch sequencer for the IF stage.
- Owns the program counter and drives the instruction-memory request handshake.
- Generates write-enable and flush controls for the IF/ID pipeline register.
- Resolves hazard-unit stalls and taken-branch redirects arriving from later stages.
- Sits between the hazard/branch logic and the IF selection mux plus IF/ID register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
PC_STEP, 4, sequential PC increment in bytes

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  reset, asynchronous, active-low
STALL  input  1  hazard unit: hold IF/ID and PC
BRANCH_TAKEN  input  1  redirect request from branch resolution
BRANCH_TARGET  input  32  redirect address
IMEM_READY  input  1  instruction memory: data for outstanding request valid this cycle
IMEM_REQ  output  1  instruction memory read request
IMEM_ADDR  output  32  instruction memory read address
IF_ID_WE  output  1  IF/ID register load enable
IF_ID_FLUSH  output  1  IF/ID register clear (insert bubble)
PC_OUT  output  32  current PC
PC_PLUS4  output  32  PC_OUT + PC_STEP, feeds IF/ID next-address field

Behaviour:
- Clocking and reset: one clock, CLK. RST_N is asynchronous and active-low.
- While RST_N=0:
  - PC=RESET_PC; state=BOOT.
  - IMEM_REQ=0, IF_ID_WE=0, IF_ID_FLUSH=0.
  - IMEM_ADDR=RESET_PC, PC_PLUS4=RESET_PC+PC_STEP.
- Registered vs combinational:
  - PC and state are registered.
  - IMEM_ADDR = PC_OUT.
  - PC_PLUS4 = PC_OUT + PC_STEP, mod 2^32 (0xFFFFFFFC + 4 = 0x00000000).
  - IMEM_REQ, IF_ID_WE and IF_ID_FLUSH are combinational from state and inputs, so they are valid in the same cycle.
- Redirect address: BRANCH_TARGET[1:0] forced to 2'b00 before loading PC.
- Priority: BRANCH_TAKEN > STALL > IMEM_READY.
- States:
  - BOOT: outputs idle. Next cycle -> FETCH unconditionally. BRANCH_TAKEN in BOOT is ignored.
  - FETCH: IMEM_REQ=1. IMEM_ADDR is held stable until the request completes (IMEM_READY=1) or is abandoned by a redirect.
    - BRANCH_TAKEN=1: PC<=target; IF_ID_FLUSH=1; IF_ID_WE=0. If IMEM_READY=1 -> stay FETCH, else -> DRAIN (request in flight).
    - STALL=1 and IMEM_READY=1: IF_ID_WE=0; PC held; -> HOLD.
    - STALL=1 and IMEM_READY=0: keep waiting in FETCH. The STALL check repeats when READY arrives.
    - IMEM_READY=1, no stall/branch: IF_ID_WE=1; PC<=PC+PC_STEP; stay FETCH. Back-to-back fetch is allowed: one instruction per cycle when READY is tied high.
  - HOLD: IMEM_REQ=0; PC held; IF_ID_WE=0.
    - BRANCH_TAKEN=1: PC<=target; IF_ID_FLUSH=1; -> FETCH.
    - Else STALL=0 -> FETCH, which re-requests the same PC.
  - DRAIN: IMEM_REQ=0; waits for the abandoned response.
    - IMEM_READY=1: data is discarded; IF_ID_WE=0; -> FETCH.
    - BRANCH_TAKEN=1 in DRAIN: PC<=new target; IF_ID_FLUSH=1. Stays DRAIN unless IMEM_READY=1 in the same cycle, then -> FETCH.
- IMEM_READY while IMEM_REQ=0 and not in DRAIN: ignored.
- IF_ID_WE and IF_ID_FLUSH are never both 1.
- At most one request is outstanding. The memory must not return READY without a request.
- Reset asserted in any state (including DRAIN): immediate return to reset values; the in-flight response is forgotten. The memory side is reset by the same RST_N.

Test Plan:
- Reset release, IMEM_READY tied 1, RESET_PC=0 -> cycle 1 BOOT (IMEM_REQ=0). Then IMEM_ADDR=0x0,0x4,0x8,... on consecutive cycles; IF_ID_WE=1 every cycle; PC_PLUS4=PC_OUT+4.
- READY asserted 2 cycles after each request -> IMEM_ADDR stable for 3 cycles per fetch; IF_ID_WE pulses once per 3 cycles; PC steps 0x0->0x4->0x8.
- At PC=0x8, STALL=1 for 3 cycles coincident with READY -> IF_ID_WE=0, PC stays 0x8, IMEM_REQ=0 during HOLD. After STALL falls, IMEM_ADDR=0x8 is re-requested and loaded.
- PC=0x10, READY=1, BRANCH_TAKEN=1, TARGET=0x103 -> IF_ID_FLUSH=1 for exactly one cycle, IF_ID_WE=0; next IMEM_ADDR=0x100. Also: STALL=1 in the same cycle is overridden by the branch.
- Branch to 0x200 while request to 0x20 is outstanding (READY=0) -> IMEM_REQ=0 in DRAIN. The late READY produces IF_ID_WE=0. The next cycle requests 0x200. A second branch to 0x300 during DRAIN -> second flush pulse, fetch resumes at 0x300.
- PC=0xFFFFFFFC with READY=1 -> PC wraps to 0x00000000. Asserting RST_N=0 mid-DRAIN -> outputs return to reset values immediately, with no clock edge required.
